// File: rtl/d_latch_pkg.sv
// Shared constants for the D-latch storage element.
package d_latch_pkg;

  // Default data width of one latch instance.
  localparam int unsigned DLATCH_DEF_WIDTH = 1;

endpackage : d_latch_pkg

// File: rtl/d_latch.sv
// Level-sensitive D latch with asynchronous active-low clear.
// R low clears Q regardless of EN and D. EN high makes Q follow D.
// EN low holds the last value.
// Q may be X at power-up, until R has been driven low once.
module d_latch
  import d_latch_pkg::*;
#(
  parameter int unsigned WIDTH = DLATCH_DEF_WIDTH
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             R
);

  // Storage element: clear has priority, then transparency, else hold.
  always_latch begin
    if (!R) begin
      Q <= '0;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule : d_latch

// File: tb/tb_d_latch.sv
// Directed bench for d_latch (WIDTH=1 and WIDTH=4) with an expected-value queue.
module tb_d_latch;

  typedef struct {
    string      tag;
    logic       wide;
    logic [3:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  logic       d1;
  logic       en1;
  logic       r1;
  logic       q1;
  logic [3:0] d4;
  logic       en4;
  logic       r4;
  logic [3:0] q4;

  d_latch #(.WIDTH(1)) u_dut1 (
    .Q  (q1),
    .D  (d1),
    .EN (en1),
    .R  (r1)
  );

  d_latch #(.WIDTH(4)) u_dut4 (
    .Q  (q4),
    .D  (d4),
    .EN (en4),
    .R  (r4)
  );

  // Pop the oldest expectation and compare it against the matching DUT output.
  task automatic check_next();
    exp_t       e;
    logic [3:0] obs;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e   = exp_q.pop_front();
    obs = e.wide ? q4 : {3'b000, q1};
    n_checks++;
    assert (obs === e.exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  // Drive the 1-bit latch, record the expected Q, sample 10 time units later.
  task automatic step1(input logic d, input logic en, input logic r,
                       input logic exp, input string tag);
    exp_t e;
    d1  = d;
    en1 = en;
    r1  = r;
    e.tag  = tag;
    e.wide = 1'b0;
    e.exp  = {3'b000, exp};
    exp_q.push_back(e);
    #10;
    check_next();
  endtask

  // Same for the 4-bit latch.
  task automatic step4(input logic [3:0] d, input logic en, input logic r,
                       input logic [3:0] exp, input string tag);
    exp_t e;
    d4  = d;
    en4 = en;
    r4  = r;
    e.tag  = tag;
    e.wide = 1'b1;
    e.exp  = exp;
    exp_q.push_back(e);
    #10;
    check_next();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    d1 = 1'b0; en1 = 1'b0; r1 = 1'b0;
    d4 = 4'h0; en4 = 1'b0; r4 = 1'b0;
    #5;

    // Reset dominates transparency.
    step1(1'b0, 1'b1, 1'b0, 1'b0, "rst_en_d0");
    step1(1'b1, 1'b1, 1'b0, 1'b0, "rst_en_d1");
    step1(1'b0, 1'b1, 1'b0, 1'b0, "rst_en_d0b");
    step1(1'b0, 1'b0, 1'b0, 1'b0, "rst_en_fall");

    // Release reset with EN low: stays 0, D ignored.
    step1(1'b0, 1'b0, 1'b1, 1'b0, "rrise_hold");
    step1(1'b1, 1'b0, 1'b1, 1'b0, "hold_d1");
    step1(1'b0, 1'b0, 1'b1, 1'b0, "hold_d0");

    // Latch high, then hold.
    step1(1'b1, 1'b0, 1'b1, 1'b0, "pre_d1");
    step1(1'b1, 1'b1, 1'b1, 1'b1, "open_d1");
    step1(1'b1, 1'b0, 1'b1, 1'b1, "close_d1");
    step1(1'b0, 1'b0, 1'b1, 1'b1, "hold1_d0");

    // Latch low, then hold.
    step1(1'b0, 1'b1, 1'b1, 1'b0, "open_d0");
    step1(1'b0, 1'b0, 1'b1, 1'b0, "close_d0");
    step1(1'b1, 1'b0, 1'b1, 1'b0, "hold0_d1");

    // Transparency tracking, hold, clear mid-hold, release with EN low.
    step1(1'b0, 1'b1, 1'b1, 1'b0, "track_0");
    step1(1'b1, 1'b1, 1'b1, 1'b1, "track_1");
    step1(1'b0, 1'b1, 1'b1, 1'b0, "track_0b");
    step1(1'b1, 1'b1, 1'b1, 1'b1, "track_1b");
    step1(1'b1, 1'b0, 1'b1, 1'b1, "close_track");
    step1(1'b1, 1'b0, 1'b0, 1'b0, "clr_mid_hold");
    step1(1'b1, 1'b0, 1'b1, 1'b0, "rrise_en0");

    // Clear mid-transparency, then release with EN high takes D at once.
    step1(1'b1, 1'b1, 1'b1, 1'b1, "reopen_d1");
    step1(1'b1, 1'b1, 1'b0, 1'b0, "clr_mid_open");
    step1(1'b1, 1'b1, 1'b1, 1'b1, "rrise_en1");

    // 4-bit instance.
    step4(4'h0, 1'b0, 1'b0, 4'h0, "w4_rst");
    step4(4'hA, 1'b1, 1'b1, 4'hA, "w4_open_a");
    step4(4'hA, 1'b0, 1'b1, 4'hA, "w4_close");
    step4(4'h5, 1'b0, 1'b1, 4'hA, "w4_hold_5");
    step4(4'h5, 1'b0, 1'b0, 4'h0, "w4_clr");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_d_latch
